// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB state walk with per-state datapath strobes.
// Optional addi support is compiled in when MCTRL_ADDI_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MCTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;

  logic       pc_write_c;
  logic       pc_write_cond_c;
  logic       i_or_d_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       mem_to_reg_c;
  logic       reg_dst_c;
  logic       reg_write_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic [1:0] pc_source_c;
  logic       instr_done_c;
  logic       illegal_op_c;

  // State register and retired-instruction counter; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done_c) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode; unlisted strobes stay 0 and unreachable codes fall back to FETCH.
  always_comb begin
    state_d         = S_FETCH;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    pc_source_c     = 2'b00;
    instr_done_c    = 1'b0;
    illegal_op_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (opcode)
          OP_R:         state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MCTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
          default: begin
            illegal_op_c = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        state_d    = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_c  = 1'b1;
        i_or_d_c     = 1'b1;
        instr_done_c = mem_ready;
        state_d      = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        instr_done_c    = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c   = 1'b1;
        pc_source_c  = 2'b10;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
`ifdef MCTRL_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Every output reads as zero while reset is held, including the debug state and the counter.
  assign pc_write      = ~rst & pc_write_c;
  assign pc_write_cond = ~rst & pc_write_cond_c;
  assign i_or_d        = ~rst & i_or_d_c;
  assign mem_read      = ~rst & mem_read_c;
  assign mem_write     = ~rst & mem_write_c;
  assign ir_write      = ~rst & ir_write_c;
  assign mem_to_reg    = ~rst & mem_to_reg_c;
  assign reg_dst       = ~rst & reg_dst_c;
  assign reg_write     = ~rst & reg_write_c;
  assign alu_src_a     = ~rst & alu_src_a_c;
  assign alu_src_b     = rst ? 2'b00 : alu_src_b_c;
  assign alu_op        = rst ? 2'b00 : alu_op_c;
  assign pc_source     = rst ? 2'b00 : pc_source_c;
  assign instr_done    = ~rst & instr_done_c;
  assign illegal_op    = ~rst & illegal_op_c;
  assign state         = rst ? 4'd0 : 4'(state_q);
  assign instr_count   = rst ? '0 : count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction state paths drive a cycle-level model that is checked every cycle.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;
`ifdef MCTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;

  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [15:0] instr_count;

  logic pc_write_w, pc_write_cond_w, i_or_d_w, mem_read_w, mem_write_w, ir_write_w;
  logic mem_to_reg_w, reg_dst_w, reg_write_w, alu_src_a_w, instr_done_w, illegal_op_w;
  logic [1:0] alu_src_b_w, alu_op_w, pc_source_w;
  logic [3:0] state_w;
  logic [2:0] instr_count_w;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  // Narrow-counter copy on the same stimulus, so counter wrap is reached in a few instructions.
  multicycle_ctrl #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_w), .pc_write_cond(pc_write_cond_w), .i_or_d(i_or_d_w),
    .mem_read(mem_read_w), .mem_write(mem_write_w), .ir_write(ir_write_w),
    .mem_to_reg(mem_to_reg_w), .reg_dst(reg_dst_w), .reg_write(reg_write_w),
    .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w), .alu_op(alu_op_w),
    .pc_source(pc_source_w), .instr_done(instr_done_w), .illegal_op(illegal_op_w),
    .state(state_w), .instr_count(instr_count_w)
  );

  logic [17:0] obs, obs_w;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op};
  assign obs_w = {pc_write_w, pc_write_cond_w, i_or_d_w, mem_read_w, mem_write_w, ir_write_w,
                  mem_to_reg_w, reg_dst_w, reg_write_w, alu_src_a_w, alu_src_b_w, alu_op_w,
                  pc_source_w, instr_done_w, illegal_op_w};

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  int ncyc = 0;
  int obs_mw = 0, obs_done = 0, obs_ill = 0;
  int seen_state = 0, seen_mr = 0, seen_cnt = 0;

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (ADDI_EN && op == OP_ADDI);
  endfunction

  // State sequence an instruction walks through (4'd15 terminates the list).
  function automatic logic [3:0] path_state(input logic [5:0] op, input int idx);
    logic [3:0] p [5];
    for (int i = 0; i < 5; i++) p[i] = 4'd15;
    p[0] = 4'd0;
    p[1] = 4'd1;
    if (op == OP_R)        begin p[2] = 4'd6;  p[3] = 4'd7; end
    else if (op == OP_LW)  begin p[2] = 4'd2;  p[3] = 4'd3; p[4] = 4'd4; end
    else if (op == OP_SW)  begin p[2] = 4'd2;  p[3] = 4'd5; end
    else if (op == OP_BEQ) p[2] = 4'd8;
    else if (op == OP_J)   p[2] = 4'd9;
    else if (ADDI_EN && op == OP_ADDI) begin p[2] = 4'd10; p[3] = 4'd11; end
    return p[idx];
  endfunction

  // Strobe list per state, packed in the same order as obs.
  function automatic logic [17:0] expect_strobes(input logic [3:0] st, input logic [5:0] op,
                                                 input logic rdy);
    logic pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, done, ill;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  begin asb = 2'b11; ill = !is_legal(op); end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mw = 1; iod = 1; done = rdy; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; done = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
      4'd9:  begin pcw = 1; psrc = 2'b10; done = 1; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, compare both DUTs against the model mid-cycle, then advance the model.
  task automatic cyc(input logic r, input logic [3:0] st, input logic rdy);
    logic [17:0] e;
    logic [3:0]  es;
    logic [15:0] ec;
    rst = r;
    mem_ready = rdy;
    e  = r ? 18'd0 : expect_strobes(st, opcode, rdy);
    es = r ? 4'd0 : st;
    ec = r ? 16'd0 : 16'(model_cnt);
    @(negedge clk);
    checks++;
    if (state !== es) begin
      errors++;
      $display("FAIL state @%0t: got %0d expected %0d", $time, state, es);
    end
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL strobes @%0t state %0d: got %b expected %b", $time, es, obs, e);
    end
    checks++;
    if (instr_count !== ec) begin
      errors++;
      $display("FAIL instr_count @%0t: got %0d expected %0d", $time, instr_count, ec);
    end
    checks++;
    if (state_w !== es || obs_w !== e || instr_count_w !== ec[2:0]) begin
      errors++;
      $display("FAIL narrow_dut @%0t: got st=%0d %b cnt=%0d expected st=%0d %b cnt=%0d",
               $time, state_w, obs_w, instr_count_w, es, e, ec[2:0]);
    end
    seen_state = int'(state);
    seen_mr    = int'(mem_read);
    seen_cnt   = int'(instr_count);
    if (mem_write)  obs_mw++;
    if (instr_done) obs_done++;
    if (illegal_op) obs_ill++;
    ncyc++;
    @(posedge clk);
    #1;
    if (r) model_cnt = 0;
    else if (e[1]) model_cnt = (model_cnt + 1) & 16'hFFFF;
  endtask

  // Run path entries [first, stop) of an instruction; memory-wait states get fwait/mwait stall cycles.
  task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input int first, input int stop);
    logic [3:0] st;
    opcode = op;
    for (int i = first; i < stop; i++) begin
      st = path_state(op, i);
      if (st == 4'd15) break;
      if (st == 4'd0 || st == 4'd3 || st == 4'd5) begin
        for (int w = 0; w < ((st == 4'd0) ? fwait : mwait); w++) cyc(1'b0, st, 1'b0);
        cyc(1'b0, st, 1'b1);
      end else begin
        cyc(1'b0, st, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  int c0, mw0, d0, i0;

  initial begin
    rst = 1'b1;
    opcode = 6'd0;
    mem_ready = 1'b0;

    cyc(1'b1, 4'd0, 1'b0);
    cyc(1'b1, 4'd0, 1'b1);

    opcode = OP_LW;
    cyc(1'b0, 4'd0, 1'b1);
    lit("post_rst_state", seen_state, 0);
    lit("post_rst_mem_read", seen_mr, 1);
    lit("post_rst_count", seen_cnt, 0);
    c0 = ncyc - 1; d0 = obs_done;
    run_instr(OP_LW, 0, 0, 1, 5);
    lit("lw_cycles", ncyc - c0, 5);
    lit("lw_done_pulses", obs_done - d0, 1);
    lit("lw_count", int'(instr_count), 1);

    c0 = ncyc; mw0 = obs_mw; d0 = obs_done;
    run_instr(OP_SW, 0, 3, 0, 5);
    lit("sw_cycles", ncyc - c0, 7);
    lit("sw_mem_write_cycles", obs_mw - mw0, 4);
    lit("sw_done_pulses", obs_done - d0, 1);
    lit("sw_count", int'(instr_count), 2);

    c0 = ncyc;
    run_instr(OP_BEQ, 0, 0, 0, 5);
    lit("beq_cycles", ncyc - c0, 3);
    c0 = ncyc;
    run_instr(OP_J, 0, 0, 0, 5);
    lit("j_cycles", ncyc - c0, 3);
    lit("beq_j_count", int'(instr_count), 4);

    c0 = ncyc; i0 = obs_ill;
    run_instr(OP_BAD, 0, 0, 0, 5);
    lit("illegal_cycles", ncyc - c0, 2);
    lit("illegal_pulses", obs_ill - i0, 1);
    lit("illegal_count", int'(instr_count), 4);

    c0 = ncyc; i0 = obs_ill;
    run_instr(OP_ADDI, 0, 0, 0, 5);
    lit("addi_cycles", ncyc - c0, ADDI_EN ? 4 : 2);
    lit("addi_illegal_pulses", obs_ill - i0, ADDI_EN ? 0 : 1);
    lit("addi_count", int'(instr_count), ADDI_EN ? 5 : 4);

    c0 = ncyc;
    run_instr(OP_LW, 2, 1, 0, 5);
    lit("lw_stall_cycles", ncyc - c0, 8);
    c0 = ncyc;
    run_instr(OP_R, 0, 0, 0, 5);
    lit("r_cycles", ncyc - c0, 4);
    lit("r_count", int'(instr_count), ADDI_EN ? 7 : 6);

    run_instr(OP_R, 0, 0, 0, 3);
    cyc(1'b1, 4'd0, 1'b1);
    lit("abort_count", int'(instr_count), 0);
    lit("abort_state", int'(state), 0);

    for (int k = 0; k < 8; k++) run_instr(OP_J, 0, 0, 0, 5);
    lit("wrap_narrow_at_8", int'(instr_count_w), 0);
    lit("wide_at_8", int'(instr_count), 8);
    run_instr(OP_J, 0, 0, 0, 5);
    lit("wrap_narrow_at_9", int'(instr_count_w), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
